cke_sched: RTL

//   Multi-channel clock-enable scheduler built on one shared prescaler.
//   The prescaler divides clk by DIV into a base tick. NCH independent channels count base ticks.

---
 rtl/cke_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cke_sched.sv
// cke_sched: multi-channel clock-enable scheduler on one shared prescaler.
//   A prescaler divides clk by DIV into base_tick. Each of NCH channels counts
//   base ticks and emits a one-cycle ce pulse on expiry, one-shot or periodic.
//   Channels are configured through a single valid/ready write port.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cfg_valid       config write request
//   cfg_ready       write accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch          target channel; values >= NCH are accepted and ignored
//   cfg_start       1 = (re)start channel, 0 = stop channel
//   cfg_periodic    1 = periodic reload, 0 = one-shot
//   cfg_period      period in base ticks, 0 treated as 1
//   base_tick       one-cycle pulse every DIV clk cycles (combinational)
//   ce              per-channel registered expiry pulse
//   active          per-channel RUN state
module cke_sched #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 16,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic           cfg_start,
  input  logic           cfg_periodic,
  input  logic [PW-1:0]  cfg_period,
  output logic           base_tick,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] active
);

  localparam int unsigned  CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  logic [CW-1:0]  cnt_q;
  logic           rec_q;
  logic           acc;
  logic [PW-1:0]  cfg_per_eff;
  logic [NCH-1:0] hit;

  ch_state_t      st_q  [NCH];
  ch_state_t      st_d  [NCH];
  logic [PW-1:0]  rem_q [NCH];
  logic [PW-1:0]  rem_d [NCH];
  logic [PW-1:0]  per_q [NCH];
  logic [PW-1:0]  per_d [NCH];
  logic [NCH-1:0] prd_q;
  logic [NCH-1:0] prd_d;
  logic [NCH-1:0] ce_d;

  // Write recovery: one dead cycle after every accepted write.
  assign cfg_ready   = ~rst & ~rec_q;
  assign acc         = cfg_valid & cfg_ready;
  assign cfg_per_eff = (cfg_period == '0) ? PW'(1) : cfg_period;
  assign base_tick   = (cnt_q == CNT_LAST);

  // Channel address decode; out-of-range addresses match no channel.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (acc && (cfg_ch == CHW'(i))) hit[i] = 1'b1;
    end
  end

  // Per-channel next state; an accepted write overrides a same-cycle tick.
  always_comb begin
    ce_d  = '0;
    prd_d = prd_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      rem_d[i] = rem_q[i];
      per_d[i] = per_q[i];
      if (hit[i]) begin
        if (cfg_start) begin
          st_d[i]  = RUN;
          per_d[i] = cfg_per_eff;
          rem_d[i] = cfg_per_eff;
          prd_d[i] = cfg_periodic;
        end else begin
          st_d[i]  = IDLE;
          rem_d[i] = '0;
        end
      end else if ((st_q[i] == RUN) && base_tick) begin
        if (rem_q[i] == PW'(1)) begin
          ce_d[i] = 1'b1;
          if (prd_q[i]) begin
            rem_d[i] = per_q[i];
          end else begin
            st_d[i]  = IDLE;
            rem_d[i] = '0;
          end
        end else begin
          rem_d[i] = rem_q[i] - PW'(1);
        end
      end
    end
  end

  // Prescaler, handshake recovery and channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rec_q <= 1'b0;
      ce    <= '0;
      prd_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        rem_q[i] <= '0;
        per_q[i] <= '0;
      end
    end else begin
      cnt_q <= base_tick ? '0 : cnt_q + CW'(1);
      rec_q <= acc;
      ce    <= ce_d;
      prd_q <= prd_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        rem_q[i] <= rem_d[i];
        per_q[i] <= per_d[i];
      end
    end
  end

  // Channel is active exactly while its FSM is in RUN.
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      active[i] = (st_q[i] == RUN);
    end
  end

endmodule
